uart_rx_cell: RTL and testbench
===============================

Name: uart_rx_cell

Overview:
- UART receive side for the matrix-cell link. It is the far end of the serial transmitter in `main`.
- Deserializes one W-bit cell per frame from the `rx` line, checks optional even parity and the stop bit, and presents the word with a one-cycle `valid` pulse.
- Sits between the serial pin and the receive-side matrix store that drives `r_cell`.

Parameters:
- W, 11, data bits per frame, LSB first.
- DIV, 10, clk cycles per bit period; must be >= 4.
- PAR, 1, 1 = even-parity bit after the data bits; 0 = no parity bit.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idle high; asynchronous to clk.
- data  output  W  last received word.
- valid  output  1  one-cycle pulse when a frame completes.
- busy  output  1  high from start-bit detection until return to IDLE.
- parity_err  output  1  pulse aligned with valid; parity mismatch (always 0 when PAR=0).
- frame_err  output  1  pulse aligned with valid; stop bit sampled 0.

Behaviour:
- Reset values (rst=0, asynchronous): data=0, valid=0, busy=0, parity_err=0, frame_err=0. State=IDLE, counters=0, synchronizer flops=1.
- Reset mid-frame: the partial frame is discarded and no valid pulse is produced.
- Synchronizer: rx passes through 2 flops to produce rx_s. All decisions use rx_s.
- Frame format: start(0), W data bits LSB first, parity bit if PAR=1, stop(1). Total N = W+PAR+2 bit periods.
- Even parity rule: the XOR of the data bits and the parity bit must be 0.
- Timing constant: H = DIV/2, integer division. A bit-cycle counter counts 0..DIV-1.
- State IDLE:
  - busy=0.
  - When rx_s==0, go to START, set busy=1, clear the counter.
- State START:
  - At counter==H-1 (mid start bit), sample rx_s.
  - If the sample is 1, it is a false start: go to IDLE with busy=0 and no pulses.
  - If the sample is 0, go to DATA and restart the counter. Subsequent samples occur every DIV cycles.
- State DATA:
  - Sample W bits into a shift register, LSB first.
  - After bit W-1, go to PARITY if PAR=1, else STOP.
- State PARITY: sample one bit and compute the parity error.
- State STOP: sample the stop bit.
  - In the next cycle, data is updated with the shift register contents and valid=1.
  - parity_err and frame_err are driven in that same cycle.
  - data is updated even when an error is flagged.
  - If stop==1, go to IDLE.
  - If stop==0, go to BREAK.
- State BREAK:
  - busy stays 1.
  - Wait until rx_s==1, then go to IDLE. This prevents a held-low line from retriggering.
- Latency: valid rises 1 cycle after the stop-bit sample. The stop-bit sample is H-1 + (N-1)*DIV cycles after entering START.
- Back-to-back frames: the FSM returns to IDLE in the same cycle valid pulses, i.e. mid stop bit. A start edge arriving one stop period later is detected normally.
- data holds its value between frames. There is no overrun signalling, and the consumer must take data on valid.
- Error pulses are 0 whenever valid is 0.

Optional Feature:
- Macro: UART_RX_GLITCH_FILTER_EN.
- Defined: each bit value (start, data, parity, stop) is the majority of three rx_s samples at counter positions m-1, m and m+1 around the nominal sample point m. The decision is taken at m+1, so all downstream timing, including valid, shifts by +1 cycle.
- Not defined: a single sample at m, with the timing stated above.

Test Plan:
- W=11, DIV=10, PAR=1, drive frame with data 8 (parity 1) -> exactly one valid pulse; data=8, parity_err=0, frame_err=0, busy low after the pulse.
- Frames 1365 (parity 0), then 682 (parity 1), back-to-back with a single stop bit -> two valid pulses; data=1365 then 682; no errors.
- Frame 1365 with parity bit forced 1 -> valid with parity_err=1, data=1365. With PAR=0 the same bench omits the parity bit and parity_err stays 0.
- Stop bit driven 0, line held low for 50 cycles, then high -> valid with frame_err=1. busy stays 1 until the line goes high, and no second frame is decoded.
- rx low for 3 cycles only (< H) -> busy pulses high, then returns to IDLE; no valid pulse.
- rst asserted at data bit 5 of a frame, released, then a full frame of 4 -> no pulse for the aborted frame. Outputs reach 0 immediately on rst, and the subsequent frame gives data=4.
- With UART_RX_GLITCH_FILTER_EN: a 1-cycle inverted glitch exactly at the bit-3 sample point of value 8 -> data=8, no errors. Without the macro, the same stimulus gives data=0 and parity_err=1.

Source files
------------

// File: rtl/uart_rx_cell_if.sv
// Receive-side bundle for uart_rx_cell: the serial line in, the decoded word and status out.
// master is the receiver's view, slave is the consumer/line-driver view.
interface uart_rx_cell_if #(
  parameter int W = 11
);
  logic         rx;
  logic [W-1:0] data;
  logic         valid;
  logic         busy;
  logic         parity_err;
  logic         frame_err;

  modport master (input rx, output data, valid, busy, parity_err, frame_err);
  modport slave  (output rx, input data, valid, busy, parity_err, frame_err);
endinterface

// File: rtl/uart_rx_cell.sv
// UART receiver for the matrix-cell link: start, W data bits LSB first, optional even parity, stop.
// Optional macro UART_RX_GLITCH_FILTER_EN: 3-sample majority vote per bit, decision one cycle later.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle, waiting for rx_s low
// S_START  | qualifying start bit at its midpoint
// S_DATA   | sampling W data bits, one every DIV cycles
// S_PARITY | sampling the even-parity bit (PAR=1 only)
// S_STOP   | sampling stop bit; result published on the following cycle
// S_BREAK  | stop bit was low; wait for line high so it cannot retrigger
module uart_rx_cell #(
  parameter int W   = 11,
  parameter int DIV = 10,
  parameter int PAR = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_cell_if.master bus
);

  localparam int H  = DIV / 2;
  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(W);
`ifdef UART_RX_GLITCH_FILTER_EN
  localparam int START_PT = H;
`else
  localparam int START_PT = H - 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [W-1:0]   shift_q, shift_d;
  logic           par_q, par_d;
  logic           perr_pend_q, perr_pend_d;
  logic [W-1:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           perr_q, perr_d;
  logic           ferr_q, ferr_d;
  logic           sync1_q, rx_s_q;
  logic           bit_v;

`ifdef UART_RX_GLITCH_FILTER_EN
  logic rx_h1_q, rx_h2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_h1_q <= 1'b1;
      rx_h2_q <= 1'b1;
    end else begin
      rx_h1_q <= rx_s_q;
      rx_h2_q <= rx_h1_q;
    end
  end

  assign bit_v = (rx_h2_q & rx_h1_q) | (rx_h2_q & rx_s_q) | (rx_h1_q & rx_s_q);
`else
  assign bit_v = rx_s_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      perr_pend_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sync1_q     <= bus.rx;
      rx_s_q      <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      perr_pend_q <= perr_pend_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    perr_pend_d = perr_pend_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    perr_d      = 1'b0;
    ferr_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d     = S_START;
          bit_cnt_d   = '0;
          par_d       = 1'b0;
          perr_pend_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == CW'(START_PT)) begin
          cnt_d   = '0;
          state_d = bit_v ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d     = '0;
          shift_d   = {bit_v, shift_q[W-1:1]};
          par_d     = par_q ^ bit_v;
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(W - 1)) begin
            state_d = (PAR != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d       = '0;
          perr_pend_d = par_q ^ bit_v;
          state_d     = S_STOP;
        end
      end
      S_STOP: begin
        // Leave mid stop bit so a back-to-back start edge is caught.
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          data_d  = shift_q;
          perr_d  = perr_pend_q;
          ferr_d  = ~bit_v;
          state_d = bit_v ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.data       = data_q;
  assign bus.valid      = valid_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx_cell.sv
// Scoreboard bench for uart_rx_cell: a line driver pushes the expected word per frame,
// a monitor pops and compares on every valid pulse.
module tb_uart_rx_cell;
  localparam int W   = 11;
  localparam int DIV = 10;
  localparam int PAR = 1;
  localparam int H   = DIV / 2;

  typedef struct packed {
    logic [W-1:0] data;
    logic         perr;
    logic         ferr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t e_mon;
  logic prev_valid = 1'b0;

  uart_rx_cell_if #(.W(W)) u_if ();

  uart_rx_cell #(.W(W), .DIV(DIV), .PAR(PAR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare whenever the DUT pulses valid.
  always @(negedge clk) begin
    if (u_if.valid === 1'b1) begin
      chk("single_cycle_valid", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=data %0d required=no pulse at %0t", u_if.data, $time);
      end else begin
        e_mon = exp_q.pop_front();
        chk("data", {21'd0, u_if.data}, {21'd0, e_mon.data});
        chk("parity_err", {31'd0, u_if.parity_err}, {31'd0, e_mon.perr});
        chk("frame_err", {31'd0, u_if.frame_err}, {31'd0, e_mon.ferr});
      end
    end else if (rst) begin
      chk("err_without_valid", {30'd0, u_if.parity_err, u_if.frame_err}, 32'd0);
    end
    prev_valid = u_if.valid;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 u_if.rx = 1'b1;
    end
  endtask

  task automatic drive_bit(input logic b, input bit glitch);
    for (int c = 0; c < DIV; c++) begin
      @(posedge clk);
      #1 u_if.rx = (glitch && c == H) ? ~b : b;
    end
  endtask

  // Reference: what the receiver should report for this frame, then the line waveform.
  task automatic send_frame(input logic [W-1:0] d, input bit inv_par, input logic stop_v,
                            input int glitch_bit, input int tail_low);
    logic [W-1:0] seen;
    logic         pbit;
    exp_t         e;
    pbit = (^d) ^ inv_par;
    seen = d;
`ifndef UART_RX_GLITCH_FILTER_EN
    if (glitch_bit >= 0) seen[glitch_bit] = ~seen[glitch_bit];
`endif
    e.data = seen;
    e.perr = (PAR != 0) ? ((^seen) ^ pbit) : 1'b0;
    e.ferr = ~stop_v;
    exp_q.push_back(e);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < W; i++) drive_bit(d[i], glitch_bit == i);
    if (PAR != 0) drive_bit(pbit, 1'b0);
    drive_bit(stop_v, 1'b0);
    for (int i = 0; i < tail_low; i++) begin
      @(posedge clk);
      #1 u_if.rx = 1'b0;
    end
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_data"}, {21'd0, u_if.data}, 32'd0);
    chk({name, "_flags"}, {28'd0, u_if.valid, u_if.busy, u_if.parity_err, u_if.frame_err}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] rd;
    bit           rinv;
    logic         rstop;
    bit           seen_busy;
    int           guard;

    u_if.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_outputs_zero("reset");
    rst = 1'b1;
    idle(3);

    // Single clean frame
    send_frame(11'd8, 1'b0, 1'b1, -1, 0);
    idle(3);
    chk("busy_after_frame", {31'd0, u_if.busy}, 32'd0);

    // Back-to-back with a single stop bit
    send_frame(11'd1365, 1'b0, 1'b1, -1, 0);
    send_frame(11'd682, 1'b0, 1'b1, -1, 0);
    idle(DIV);

    // Parity bit inverted
    send_frame(11'd1365, 1'b1, 1'b1, -1, 0);
    idle(DIV);

    // Stop bit low, line held low: break
    send_frame(11'd8, 1'b0, 1'b0, -1, 50);
    chk("busy_in_break", {31'd0, u_if.busy}, 32'd1);
    idle(5);
    chk("busy_after_break", {31'd0, u_if.busy}, 32'd0);
    idle(2 * DIV);

    // False start shorter than H
    seen_busy = 1'b0;
    @(posedge clk);
    #1 u_if.rx = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      if (c == 2) u_if.rx = 1'b1;
      if (u_if.busy) seen_busy = 1'b1;
    end
    chk("false_start_busy_seen", {31'd0, seen_busy}, 32'd1);
    chk("false_start_idle", {31'd0, u_if.busy}, 32'd0);

    // Reset during data bit 5
    send_frame(11'd1365, 1'b0, 1'b1, -1, 0);
    idle(DIV);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk_outputs_zero("midframe_reset");
    u_if.rx = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(3 * DIV);
    send_frame(11'd4, 1'b0, 1'b1, -1, 0);
    idle(DIV);

    // One-cycle glitch at the data bit 3 sample point
    send_frame(11'd8, 1'b0, 1'b1, 3, 0);
    idle(DIV);

    // Random frames
    for (int n = 0; n < 20; n++) begin
      rd    = W'($urandom_range(0, (1 << W) - 1));
      rinv  = ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 4) != 0);
      send_frame(rd, rinv, rstop, -1, 0);
      if (rstop) idle($urandom_range(0, DIV));
      else idle(2 * DIV);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    idle(2 * DIV);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
